game_round_controller: RTL and testbench

Clocked sequencer for one round of the binary number game.
- Fires the number generator, then loads the countdown timer.
- Judges the player's guess against the comparator result or a timer expiry.
- Advances the level and shortens the round time on each correct guess.
- Sits between the button/comparator/timer blocks and the generator/timer/display, and owns game_state, level and the timer load value.

---
 rtl/game_pkg.sv | 38 +++
 rtl/hold_counter.sv | 22 ++
 rtl/game_round_controller.sv | 109 ++++++++++
 tb/tb_game_round_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the number-game round controller and its display.
package game_pkg;

  localparam int TIME_W = 5;

  localparam logic [1:0] GS_IDLE = 2'd0;
  localparam logic [1:0] GS_PLAY = 2'd1;
  localparam logic [1:0] GS_WIN  = 2'd2;
  localparam logic [1:0] GS_OVER = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_BLANK = 3'd3;
  localparam logic [2:0] S_PLAY  = 3'd4;
  localparam logic [2:0] S_SHOW  = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_GEN   = S_GEN,
    ST_LOAD  = S_LOAD,
    ST_BLANK = S_BLANK,
    ST_PLAY  = S_PLAY,
    ST_SHOW  = S_SHOW,
    ST_OVER  = S_OVER
  } state_t;

  // Shorter round time, clamped at min_t without wrapping below zero.
  function automatic logic [TIME_W-1:0] next_time(input logic [TIME_W-1:0] cur,
                                                  input logic [TIME_W-1:0] min_t,
                                                  input logic [TIME_W-1:0] step);
    logic [TIME_W:0] floor_step;
    floor_step = {1'b0, min_t} + {1'b0, step};
    return ({1'b0, cur} >= floor_step) ? cur - step : min_t;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter that stops at zero; used for timed indications.
module hold_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst)              count <= '0;
    else if (load)        count <= load_val;
    else if (en && !zero) count <= count - WIDTH'(1);
  end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: generate number, load timer, judge guess, advance level.
module game_round_controller
  import game_pkg::*;
#(
  parameter int START_TIME  = 20,
  parameter int MIN_TIME    = 5,
  parameter int TIME_STEP   = 1,
  parameter int MAX_LEVEL   = 99,
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              guess_b,
  input  logic              match,
  input  logic              end_f,
  output logic              g_enable,
  output logic              time_f,
  output logic [TIME_W-1:0] time_v,
  output logic [7:0]        level,
  output logic [1:0]        game_state,
  output logic              won
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [TIME_W-1:0] T_START   = TIME_W'(START_TIME);
  localparam logic [TIME_W-1:0] T_MIN     = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] T_STEP    = TIME_W'(TIME_STEP);
  localparam logic [7:0]        LV_MAX    = 8'(MAX_LEVEL);

  state_t            state;
  logic [TIME_W-1:0] cur_time;
  logic [CNT_W-1:0]  show_cnt;
  logic              show_done;
  logic              hit;

  assign hit    = (state == ST_PLAY) && guess_b && match;
  assign time_v = cur_time;

  hold_counter #(.WIDTH(CNT_W)) u_show (
    .clk      (clk),
    .rst      (rst),
    .load     (hit),
    .en       (state == ST_SHOW),
    .load_val (SHOW_LOAD),
    .count    (show_cnt),
    .zero     (show_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      level      <= '0;
      cur_time   <= T_START;
      g_enable   <= 1'b0;
      time_f     <= 1'b0;
      game_state <= GS_IDLE;
      won        <= 1'b0;
    end else begin
      g_enable <= 1'b0;
      time_f   <= 1'b0;
      case (state)
        ST_IDLE: if (guess_b) begin
          state      <= ST_GEN;
          g_enable   <= 1'b1;
          game_state <= GS_PLAY;
        end
        ST_GEN: begin
          state  <= ST_LOAD;
          time_f <= 1'b1;
        end
        ST_LOAD:  state <= ST_BLANK;
        // end_f may still be high from the previous round here
        ST_BLANK: state <= ST_PLAY;
        ST_PLAY: begin
          if (hit) begin
            state      <= ST_SHOW;
            game_state <= GS_WIN;
            if (level < LV_MAX) level <= level + 8'd1;
            cur_time   <= next_time(cur_time, T_MIN, T_STEP);
          end else if (guess_b || end_f) begin
            state      <= ST_OVER;
            game_state <= GS_OVER;
          end
        end
        ST_SHOW: if (show_done) begin
          if (level == LV_MAX) begin
            state      <= ST_OVER;
            game_state <= GS_OVER;
            won        <= 1'b1;
          end else begin
            state      <= ST_GEN;
            g_enable   <= 1'b1;
            game_state <= GS_PLAY;
          end
        end
        ST_OVER: if (guess_b) begin
          state      <= ST_IDLE;
          game_state <= GS_IDLE;
          level      <= '0;
          cur_time   <= T_START;
          won        <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller (SHOW_CYCLES = 4, MAX_LEVEL = 20).
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       rst, guess_b, match, end_f;
  logic       g_enable, time_f, won;
  logic [4:0] time_v;
  logic [7:0] level;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_round_controller #(
    .START_TIME(20), .MIN_TIME(5), .TIME_STEP(1), .MAX_LEVEL(20), .SHOW_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .guess_b(guess_b), .match(match), .end_f(end_f),
    .g_enable(g_enable), .time_f(time_f), .time_v(time_v), .level(level),
    .game_state(game_state), .won(won)
  );

  typedef struct {
    string name;
    logic  rst, gb, m, ef;
    logic  ge, tf;
    int    tv, lv, gs;
    logic  w;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, gb, m, ef,
                     input logic ge, tf, input int tv, lv, gs, input logic w);
    vec_t v;
    v.name = n; v.rst = r; v.gb = gb; v.m = m; v.ef = ef;
    v.ge = ge; v.tf = tf; v.tv = tv; v.lv = lv; v.gs = gs; v.w = w;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Drive inputs for one cycle, sample outputs just after the rising edge.
  task automatic step(input logic r, gb, m, ef);
    @(negedge clk);
    rst = r; guess_b = gb; match = m; end_f = ef;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string n, input logic ge, tf, input int tv, lv, gs,
                         input logic w);
    chk({n, ".g_enable"},   int'(g_enable),   int'(ge));
    chk({n, ".time_f"},     int'(time_f),     int'(tf));
    chk({n, ".time_v"},     int'(time_v),     tv);
    chk({n, ".level"},      int'(level),      lv);
    chk({n, ".game_state"}, int'(game_state), gs);
    chk({n, ".won"},        int'(won),        int'(w));
  endtask

  initial begin
    int tv_exp;
    rst = 1'b1; guess_b = 1'b0; match = 1'b0; end_f = 1'b0;

    //   name         rst gb m ef   ge tf tv lv gs won
    add("rst0",       1, 0, 0, 0,   0, 0, 20, 0, 0, 0);
    add("rst1",       1, 0, 0, 0,   0, 0, 20, 0, 0, 0);
    add("idle",       0, 0, 0, 0,   0, 0, 20, 0, 0, 0);
    add("start_gen",  0, 1, 0, 0,   1, 0, 20, 0, 1, 0);
    add("load",       0, 0, 0, 0,   0, 1, 20, 0, 1, 0);
    add("blank",      0, 0, 0, 0,   0, 0, 20, 0, 1, 0);
    add("play",       0, 0, 0, 0,   0, 0, 20, 0, 1, 0);
    add("play_wait",  0, 0, 1, 0,   0, 0, 20, 0, 1, 0);
    add("hit_show1",  0, 1, 1, 0,   0, 0, 19, 1, 2, 0);
    add("show2",      0, 0, 0, 0,   0, 0, 19, 1, 2, 0);
    add("show3",      0, 0, 0, 0,   0, 0, 19, 1, 2, 0);
    add("show4",      0, 0, 0, 0,   0, 0, 19, 1, 2, 0);
    add("regen",      0, 0, 0, 0,   1, 0, 19, 1, 1, 0);
    add("reload19",   0, 0, 0, 0,   0, 1, 19, 1, 1, 0);
    add("blank2",     0, 0, 0, 0,   0, 0, 19, 1, 1, 0);
    add("play2",      0, 0, 0, 0,   0, 0, 19, 1, 1, 0);
    add("miss_over",  0, 1, 0, 0,   0, 0, 19, 1, 3, 0);
    add("over_hold",  0, 0, 1, 1,   0, 0, 19, 1, 3, 0);
    add("restart",    0, 1, 0, 0,   0, 0, 20, 0, 0, 0);
    add("t_gen",      0, 1, 0, 0,   1, 0, 20, 0, 1, 0);
    add("t_load_ef",  0, 0, 0, 1,   0, 1, 20, 0, 1, 0);
    add("t_blank_ef", 0, 0, 0, 1,   0, 0, 20, 0, 1, 0);
    add("t_play_ef",  0, 0, 0, 1,   0, 0, 20, 0, 1, 0);
    add("timeout",    0, 0, 0, 1,   0, 0, 20, 0, 3, 0);
    add("t_restart",  0, 1, 0, 0,   0, 0, 20, 0, 0, 0);
    add("tie_gen",    0, 1, 0, 0,   1, 0, 20, 0, 1, 0);
    add("gb_in_gen",  0, 1, 0, 0,   0, 1, 20, 0, 1, 0);
    add("gb_in_load", 0, 1, 0, 0,   0, 0, 20, 0, 1, 0);
    add("gb_in_blnk", 0, 1, 0, 1,   0, 0, 20, 0, 1, 0);
    add("tie_hit",    0, 1, 1, 1,   0, 0, 19, 1, 2, 0);
    add("gb_in_show", 0, 1, 0, 1,   0, 0, 19, 1, 2, 0);
    add("tie_show3",  0, 0, 0, 1,   0, 0, 19, 1, 2, 0);
    add("tie_show4",  0, 0, 0, 1,   0, 0, 19, 1, 2, 0);
    add("tie_regen",  0, 0, 0, 0,   1, 0, 19, 1, 1, 0);
    add("tie_load",   0, 0, 0, 0,   0, 1, 19, 1, 1, 0);
    add("tie_blank",  0, 0, 0, 0,   0, 0, 19, 1, 1, 0);
    add("tie_play",   0, 0, 0, 0,   0, 0, 19, 1, 1, 0);
    add("mid_rst",    1, 1, 1, 0,   0, 0, 20, 0, 0, 0);
    add("post_rst",   0, 0, 0, 0,   0, 0, 20, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].gb, vecs[i].m, vecs[i].ef);
      chk_all(vecs[i].name, vecs[i].ge, vecs[i].tf, vecs[i].tv, vecs[i].lv,
              vecs[i].gs, vecs[i].w);
    end

    // Twenty correct rounds: time floors at 5, game ends won at level 20.
    tv_exp = 20;
    step(0, 1, 0, 0);
    chk_all("sat_gen0", 1, 0, tv_exp, 0, 1, 0);
    for (int r = 0; r < 20; r++) begin
      step(0, 0, 0, 0);
      chk("sat_load.time_f", int'(time_f), 1);
      chk("sat_load.time_v", int'(time_v), tv_exp);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      tv_exp = (tv_exp > 5) ? tv_exp - 1 : 5;
      chk_all("sat_show", 0, 0, tv_exp, r + 1, 2, 0);
      for (int s = 0; s < 3; s++) begin
        step(0, 0, 0, 0);
        chk("sat_show_hold", int'(game_state), 2);
      end
      step(0, 0, 0, 0);
      if (r < 19) chk_all("sat_regen", 1, 0, tv_exp, r + 1, 1, 0);
      else        chk_all("sat_won",   0, 0, 5, 20, 3, 1);
    end
    step(0, 0, 0, 0);
    chk_all("won_hold", 0, 0, 5, 20, 3, 1);
    step(0, 1, 0, 0);
    chk_all("won_restart", 0, 0, 20, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
